serial_feeder: RTL and testbench

SERIAL_FEEDER -- requirements
Module: serial_feeder

---
 rtl/serial_feeder.sv | 119 +++++++++++
 tb/tb_serial_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder: streams an N-bit word LSB first into a downstream shift register.
// Optional one-word hold buffer for zero-bubble back-to-back words: define SERIAL_FEEDER_HOLDBUF_EN.
module serial_feeder #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic [N-1:0] DIN,
    input  logic         DVALID,
    output logic         DREADY,
    input  logic         STALL,
    output logic         SOUT,
    output logic         EN,
    output logic         BUSY,
    output logic         DONE
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

`ifdef SERIAL_FEEDER_HOLDBUF_EN
    logic [N-1:0]  hbuf_q, hbuf_d;
    logic          hvld_q, hvld_d;

    assign DREADY = (state_q == IDLE) || !hvld_q;
`else
    assign DREADY = (state_q == IDLE);
`endif

    // All outputs decode registered state, so an asynchronous reset clears them at once.
    assign BUSY   = (state_q == SHIFT);
    assign EN     = BUSY && !STALL;
    assign DONE   = EN && (cnt_q == LAST);
    assign SOUT   = sreg_q[0];
    assign accept = DVALID && DREADY;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_FEEDER_HOLDBUF_EN
        hbuf_d  = hbuf_q;
        hvld_d  = hvld_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = DIN;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (EN) begin
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q + 1'b1;
                end
`ifdef SERIAL_FEEDER_HOLDBUF_EN
                if (accept) begin
                    hbuf_d = DIN;
                    hvld_d = 1'b1;
                end
                if (DONE) begin
                    cnt_d = '0;
                    if (hvld_q) begin
                        sreg_d = hbuf_q;
                        hvld_d = 1'b0;
                    end else if (accept) begin
                        // Word arriving on the final bit goes straight to the shifter.
                        sreg_d = DIN;
                        hvld_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
`else
                if (DONE) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef SERIAL_FEEDER_HOLDBUF_EN
            hbuf_q  <= '0;
            hvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_FEEDER_HOLDBUF_EN
            hbuf_q  <= hbuf_d;
            hvld_q  <= hvld_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// Self-checking bench for serial_feeder (N=4 and N=8 instances), scoreboard of expected words.
// Expectations follow SERIAL_FEEDER_HOLDBUF_EN when the bench is built with it defined.
module tb_serial_feeder;

    logic       clk = 1'b0;
    logic       rstn;
    logic       stall;
    logic [3:0] din4;
    logic       dv4, dready4, sout4, en4, busy4, done4;
    logic [7:0] din8;
    logic       dv8, dready8, sout8, en8, busy8, done8;

    logic [3:0] q4 = '0;
    logic [7:0] q8 = '0;
    logic [3:0] exp4_q[$];
    logic [7:0] exp8_q[$];

    int    n_checks = 0;
    int    n_fail   = 0;
    logic  sel8;
    logic  en_s, sout_s, done_s, busy_s, dready_s;
    logic [31:0] en_log, sout_log, done_log, busy_log, dready_log;

    always #5 clk = ~clk;

    serial_feeder #(.N(4)) dut4 (
        .CLK(clk), .RSTN(rstn), .DIN(din4), .DVALID(dv4), .DREADY(dready4),
        .STALL(stall), .SOUT(sout4), .EN(en4), .BUSY(busy4), .DONE(done4)
    );

    serial_feeder #(.N(8)) dut8 (
        .CLK(clk), .RSTN(rstn), .DIN(din8), .DVALID(dv8), .DREADY(dready8),
        .STALL(stall), .SOUT(sout8), .EN(en8), .BUSY(busy8), .DONE(done8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream right-shifting registers; each DONE retires one word against the scoreboard.
    always @(posedge clk) begin
        if (en4) q4 <= {sout4, q4[3:1]};
        if (done4) begin
            if (exp4_q.size() == 0) check("sb4_underflow", exp4_q.size(), 1);
            else check("word4", {28'd0, sout4, q4[3:1]}, {28'd0, exp4_q.pop_front()});
        end
        if (en8) q8 <= {sout8, q8[7:1]};
        if (done8) begin
            if (exp8_q.size() == 0) check("sb8_underflow", exp8_q.size(), 1);
            else check("word8", {24'd0, sout8, q8[7:1]}, {24'd0, exp8_q.pop_front()});
        end
    end

    task automatic clr_logs();
        en_log = '0; sout_log = '0; done_log = '0; busy_log = '0; dready_log = '0;
    endtask

    task automatic tick(input logic dv, input logic [7:0] d, input logic st);
        @(negedge clk);
        if (sel8) begin
            dv8 = dv; din8 = d; dv4 = 1'b0;
        end else begin
            dv4 = dv; din4 = d[3:0]; dv8 = 1'b0;
        end
        stall = st;
        #1;
        en_s     = sel8 ? en8     : en4;
        sout_s   = sel8 ? sout8   : sout4;
        done_s   = sel8 ? done8   : done4;
        busy_s   = sel8 ? busy8   : busy4;
        dready_s = sel8 ? dready8 : dready4;
        en_log     = {en_log[30:0], en_s};
        sout_log   = {sout_log[30:0], sout_s};
        done_log   = {done_log[30:0], done_s};
        busy_log   = {busy_log[30:0], busy_s};
        dready_log = {dready_log[30:0], dready_s};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] word;
        logic       accepted;
        int         cycles;
        logic [6:0] stall_pat;

        rstn = 1'b0; stall = 1'b0; sel8 = 1'b0;
        dv4 = 1'b0; din4 = '0; dv8 = 1'b0; din8 = '0;
        #12;
        check("rst_en", en4, 0);
        check("rst_sout", sout4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_dready", dready4, 1);

        // Word 4'hA offered together with reset release: taken on the first edge.
        @(negedge clk);
        rstn = 1'b1; dv4 = 1'b1; din4 = 4'hA;
        exp4_q.push_back(4'hA);
        #1;
        check("a_dready_idle", dready4, 1);
        check("a_en_idle", en4, 0);
        clr_logs();
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0);
        check("a_en", en_log, 32'b11110);
        check("a_sout", sout_log, 32'b01010);
        check("a_done", done_log, 32'b00010);
        check("a_busy", busy_log, 32'b11110);
        check("a_dready_after", dready_s, 1);
        check("a_q", q4, 4'hA);

        // Word 4'h6 with a three-cycle stall after the second bit.
        tick(1'b1, 8'h06, 1'b0);
        exp4_q.push_back(4'h6);
        clr_logs();
        stall_pat = 7'b0011100;
        for (int i = 6; i >= 0; i--) tick(1'b0, 8'h00, stall_pat[i]);
        check("b_en", en_log, 32'b1100011);
        check("b_sout", sout_log, 32'b0111110);
        check("b_done", done_log, 32'b0000001);
        check("b_busy", busy_log, 32'b1111111);
`ifdef SERIAL_FEEDER_HOLDBUF_EN
        check("b_dready", dready_log, 32'b1111111);
`else
        check("b_dready", dready_log, 32'b0000000);
`endif
        tick(1'b0, 8'h00, 1'b0);
        check("b_idle_en", en_s, 0);

        // Back-to-back words 4'h3 then 4'hC with DVALID held.
        tick(1'b1, 8'h03, 1'b0);
        exp4_q.push_back(4'h3);
        exp4_q.push_back(4'hC);
        clr_logs();
`ifdef SERIAL_FEEDER_HOLDBUF_EN
        for (int i = 0; i < 8; i++) tick(i == 0, 8'h0C, 1'b0);
        check("c_en", en_log, 32'b11111111);
        check("c_done", done_log, 32'b00010001);
        check("c_sout", sout_log, 32'b11000011);
`else
        for (int i = 0; i < 9; i++) tick(i < 5, 8'h0C, 1'b0);
        check("c_en", en_log, 32'b111101111);
        check("c_done", done_log, 32'b000100001);
        check("c_sout", sout_log, 32'b110000011);
`endif
        tick(1'b0, 8'h00, 1'b0);
        check("c_idle_busy", busy_s, 0);
        check("c_q", q4, 4'hC);

        // Asynchronous reset during the third bit of 4'hF; the partial word is dropped.
        tick(1'b1, 8'h0F, 1'b0);
        clr_logs();
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0);
        check("d_en_pre", en_log, 32'b111);
        #2;
        rstn = 1'b0;
        #1;
        check("d_rst_en", en4, 0);
        check("d_rst_sout", sout4, 0);
        check("d_rst_busy", busy4, 0);
        check("d_rst_done", done4, 0);
        check("d_rst_dready", dready4, 1);
        @(negedge clk);
        rstn = 1'b1;
        clr_logs();
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0);
        check("d_no_strobe", en_log, 32'b0);
        check("d_no_busy", busy_log, 32'b0);
        check("d_dready", dready_log, 32'b11111);

        // Word 4'h5 offered while 4'h9 is in flight.
        tick(1'b1, 8'h09, 1'b0);
        exp4_q.push_back(4'h9);
        clr_logs();
`ifdef SERIAL_FEEDER_HOLDBUF_EN
        exp4_q.push_back(4'h5);
        for (int i = 0; i < 8; i++) tick(i == 0, 8'h05, 1'b0);
        check("e_dready", dready_log, 32'b10001111);
        check("e_en", en_log, 32'b11111111);
        check("e_sout", sout_log, 32'b10011010);
`else
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h05, 1'b0);
        check("e_dready", dready_log, 32'b0000);
        check("e_en", en_log, 32'b1111);
        check("e_sout", sout_log, 32'b1001);
        check("e_q", {28'd0, sout4, q4[3:1]}, 4'h9);
`endif
        tick(1'b0, 8'h00, 1'b0);
        check("e_idle_en", en_s, 0);
        check("e_idle_dready", dready_s, 1);

        // Random words with random stalls, checked through the scoreboard.
        for (int w = 0; w < 6; w++) begin
            word = 4'($urandom_range(0, 15));
            accepted = 1'b0;
            for (int t = 0; t < 20 && !accepted; t++) begin
                tick(1'b1, {4'h0, word}, 1'b0);
                if (dready_s) accepted = 1'b1;
            end
            check("r_accept", accepted, 1);
            if (accepted) exp4_q.push_back(word);
            cycles = 0;
            do begin
                tick(1'b0, 8'h00, $urandom_range(0, 2) == 0);
                cycles++;
            end while (busy_s && cycles < 40);
            check("r_drain", busy_s, 0);
        end

        // N=8 instance with 8'h81.
        sel8 = 1'b1;
        tick(1'b1, 8'h81, 1'b0);
        exp8_q.push_back(8'h81);
        clr_logs();
        for (int i = 0; i < 9; i++) tick(1'b0, 8'h00, 1'b0);
        check("f_en", en_log, 32'b111111110);
        check("f_sout", sout_log, 32'b100000010);
        check("f_done", done_log, 32'b000000010);
        check("f_q", q8, 8'h81);

        check("sb4_empty", exp4_q.size(), 0);
        check("sb8_empty", exp8_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
